// File: rtl/rec_addr_gen_if.sv
// Recorder address generator port bundle.
// Mode inputs from the control FSM, RAM strobes and status back out.
interface rec_addr_gen_if #(
  parameter int ADDR_W = 16
);
  logic              able;
  logic              direc;
  logic              clea;
  logic              twice_play;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] rec_len;
  logic              full;
  logic              finish;

  modport master (
    output able, direc, clea, twice_play,
    input  mem_addr, mem_we, mem_re,
    input  rec_len, full, finish
  );

  modport slave (
    input  able, direc, clea, twice_play,
    output mem_addr, mem_we, mem_re,
    output rec_len, full, finish
  );
endinterface

// File: rtl/rec_addr_gen.sv
// Sample-rate RAM address/strobe generator for the recorder.
// Optional LOOP_PLAY_EN: play/ffwd wraps to address 0 instead of finishing.
module rec_addr_gen #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 65535,
  parameter int CLK_DIV = 6250
) (
  input logic          clk,
  input logic          rst_n,
  rec_addr_gen_if.slave bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    REC, PLAY, FFWD, RWND
  } mode_e;

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  mode_e             mode;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, re_q, fin_q;

  logic [ADDR_W-1:0] wr_nxt, rd_nxt, addr_nxt;
  logic              we_nxt, re_nxt, fin_nxt;
  logic [ADDR_W:0]   step, fwd_sum;
  logic [ADDR_W-1:0] fwd_ptr;

  assign tick = bus.able &&
                (div_cnt == DIV_W'(CLK_DIV - 1));

  always_comb begin
    mode = REC;
    unique case ({bus.direc, bus.twice_play})
      2'b00: mode = REC;
      2'b01: mode = RWND;
      2'b10: mode = PLAY;
      2'b11: mode = FFWD;
    endcase
  end

  // One extra bit so a 2x step near the top of the RAM cannot wrap
  assign step    = bus.twice_play ? (ADDR_W+1)'(2)
                                  : (ADDR_W+1)'(1);
  assign fwd_sum = {1'b0, rd_ptr} + step;
  assign fwd_ptr = (fwd_sum > {1'b0, wr_ptr}) ? wr_ptr
                 : fwd_sum[ADDR_W-1:0];

`ifdef LOOP_PLAY_EN
  logic [ADDR_W-1:0] wrap_ptr;
  // Wrap reads address 0 now, so the pointer moves on past it
  assign wrap_ptr = (step > {1'b0, wr_ptr}) ? wr_ptr
                  : step[ADDR_W-1:0];
`endif

  always_comb begin
    wr_nxt   = wr_ptr;
    rd_nxt   = rd_ptr;
    addr_nxt = addr_q;
    we_nxt   = 1'b0;
    re_nxt   = 1'b0;
    fin_nxt  = 1'b0;
    if (tick) begin
      unique case (mode)
        REC: begin
          rd_nxt = '0;
          if (wr_ptr < ADDR_W'(DEPTH)) begin
            addr_nxt = wr_ptr;
            we_nxt   = 1'b1;
            wr_nxt   = wr_ptr + 1'b1;
          end
        end
        PLAY, FFWD: begin
          if (rd_ptr < wr_ptr) begin
            addr_nxt = rd_ptr;
            re_nxt   = 1'b1;
            rd_nxt   = fwd_ptr;
          end
`ifdef LOOP_PLAY_EN
          else if (wr_ptr != '0) begin
            addr_nxt = '0;
            re_nxt   = 1'b1;
            rd_nxt   = wrap_ptr;
          end
`endif
          else begin
            fin_nxt = 1'b1;
            rd_nxt  = '0;
          end
        end
        RWND: begin
          if (rd_ptr == '0) begin
            fin_nxt = 1'b1;
          end else begin
            addr_nxt = rd_ptr - 1'b1;
            re_nxt   = 1'b1;
            rd_nxt   = (rd_ptr <= ADDR_W'(2)) ? '0
                     : rd_ptr - ADDR_W'(2);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else if (bus.clea) begin
      div_cnt <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      div_cnt <= (!bus.able || tick) ? '0
               : div_cnt + 1'b1;
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      addr_q  <= addr_nxt;
      we_q    <= we_nxt;
      re_q    <= re_nxt;
      fin_q   <= fin_nxt;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_re   = re_q;
  assign bus.finish   = fin_q;
  assign bus.rec_len  = wr_ptr;
  assign bus.full     = (wr_ptr == ADDR_W'(DEPTH));
endmodule

// File: tb/tb_rec_addr_gen.sv
// Randomised + directed bench for rec_addr_gen.
// Reference: behavioural sample-tick model, checked every cycle.
module tb_rec_addr_gen;
  localparam int AW  = 16;
  localparam int DEP = 8;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rec_addr_gen_if #(.ADDR_W(AW)) bus ();

  rec_addr_gen #(
    .ADDR_W (AW),
    .DEPTH  (DEP),
    .CLK_DIV(DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int errors  = 0;
  bit cmp_en  = 1'b0;
  int cyc     = 0;

  int wq[$];
  int wc[$];
  int rq[$];
  int nfin;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Model: recorded length, play cursor, enabled-clock count
  int m_wr, m_rd, m_ph, m_addr;
  bit m_we, m_re, m_fin;

  always @(posedge clk or negedge rst_n) begin : model
    int wr, rd, ad, ph, st;
    bit we, re, fi;
    if (!rst_n) begin
      m_wr <= 0; m_rd <= 0; m_ph <= 0; m_addr <= 0;
      m_we <= 0; m_re <= 0; m_fin <= 0;
    end else begin
      wr = m_wr; rd = m_rd; ad = m_addr; ph = m_ph + 1;
      we = 0; re = 0; fi = 0;
      st = bus.twice_play ? 2 : 1;
      if (bus.clea) begin
        wr = 0; rd = 0; ph = 0;
      end else if (!bus.able) begin
        ph = 0;
      end else if (ph == DIV) begin
        ph = 0;
        if (!bus.direc && !bus.twice_play) begin
          if (wr < DEP) begin ad = wr; we = 1; wr++; end
          rd = 0;
        end else if (bus.direc) begin
          if (rd >= wr) begin
`ifdef LOOP_PLAY_EN
            if (wr > 0) begin
              ad = 0; re = 1; rd = (st < wr) ? st : wr;
            end else begin
              fi = 1; rd = 0;
            end
`else
            fi = 1; rd = 0;
`endif
          end else begin
            ad = rd; re = 1;
            rd = (rd + st > wr) ? wr : rd + st;
          end
        end else begin
          if (rd == 0) fi = 1;
          else begin
            ad = rd - 1; re = 1;
            rd = (rd <= 2) ? 0 : rd - 2;
          end
        end
      end
      m_wr <= wr; m_rd <= rd; m_ph <= ph; m_addr <= ad;
      m_we <= we; m_re <= re; m_fin <= fi;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      chk("mem_we",   int'(bus.mem_we),   int'(m_we));
      chk("mem_re",   int'(bus.mem_re),   int'(m_re));
      chk("finish",   int'(bus.finish),   int'(m_fin));
      chk("mem_addr", int'(bus.mem_addr), m_addr);
      chk("rec_len",  int'(bus.rec_len),  m_wr);
      chk("full",     int'(bus.full),     int'(m_wr == DEP));
      if (bus.mem_we) begin
        wq.push_back(int'(bus.mem_addr));
        wc.push_back(cyc);
      end
      if (bus.mem_re) rq.push_back(int'(bus.mem_addr));
      if (bus.finish) nfin++;
    end
  end

  task automatic clrq();
    wq.delete(); wc.delete(); rq.delete(); nfin = 0;
  endtask

  task automatic seg(bit d, bit t, int n);
    @(negedge clk);
    bus.clea = 0; bus.direc = d; bus.twice_play = t;
    bus.able = 1;
    repeat (DIV * n) @(negedge clk);
    bus.able = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear();
    @(negedge clk); bus.able = 0; bus.clea = 1;
    @(negedge clk); bus.clea = 0;
    chk("clr_len",  int'(bus.rec_len), 0);
    chk("clr_full", int'(bus.full), 0);
  endtask

  task automatic chk_rq(string nm, int n, int a0, int a1, int a2, int a3);
    int exp[4];
    exp = '{a0, a1, a2, a3};
    chk({nm, "_n"}, rq.size(), n);
    for (int i = 0; i < n && i < rq.size(); i++)
      chk({nm, "_addr"}, rq[i], exp[i]);
  endtask

  initial begin
    bus.able = 0; bus.direc = 0;
    bus.clea = 0; bus.twice_play = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1; cmp_en = 1;

    clrq();
    repeat (20) @(negedge clk);
    chk("idle_we", wq.size(), 0);
    chk("idle_re", rq.size() + nfin, 0);

    clrq(); seg(0, 0, 5);
    chk("rec_n", wq.size(), 5);
    for (int i = 0; i < wq.size(); i++) begin
      chk("rec_addr", wq[i], i);
      if (i > 0) chk("rec_gap", wc[i] - wc[i-1], DIV);
    end
    chk("rec_len5", int'(bus.rec_len), 5);
    chk("rec_full", int'(bus.full), 0);

    @(posedge clk); #3 rst_n = 0; #1;
    chk("rst_len",  int'(bus.rec_len), 0);
    chk("rst_addr", int'(bus.mem_addr), 0);
    chk("rst_strb", int'({bus.mem_we, bus.mem_re, bus.finish}), 0);
    chk("rst_full", int'(bus.full), 0);
    @(negedge clk); rst_n = 1;

    clrq(); seg(0, 0, 10);
    chk("ovf_n", wq.size(), 8);
    for (int i = 0; i < wq.size(); i++) chk("ovf_addr", wq[i], i);
    chk("ovf_len",  int'(bus.rec_len), 8);
    chk("ovf_full", int'(bus.full), 1);

    clear(); seg(0, 0, 3);
    clrq(); seg(1, 0, 4);
    chk_rq("play", 3, 0, 1, 2, 0);
    chk("play_fin", nfin, 1);
    clrq(); seg(1, 0, 1);
    chk_rq("play_rst", 1, 0, 0, 0, 0);

    clear(); seg(0, 0, 5);
    clrq(); seg(1, 1, 4);
    chk_rq("ffwd", 3, 0, 2, 4, 0);
    chk("ffwd_fin", nfin, 1);
    clrq(); seg(1, 0, 5);
    clrq(); seg(0, 1, 4);
    chk_rq("rwnd", 3, 4, 2, 0, 0);
    chk("rwnd_fin", nfin, 1);

    @(negedge clk); bus.direc = 1; bus.twice_play = 0; bus.able = 1;
    repeat (6) @(negedge clk);
    bus.clea = 1;
    clrq();
    @(negedge clk);
    chk("cpl_len",  int'(bus.rec_len), 0);
    chk("cpl_full", int'(bus.full), 0);
    chk("cpl_strb", wq.size() + rq.size() + nfin, 0);
    bus.clea = 0; bus.able = 0;
    clrq(); seg(1, 0, 1);
    chk("empty_re",  rq.size(), 0);
    chk("empty_fin", nfin, 1);

    clear(); seg(0, 0, 2);
    clrq(); seg(1, 0, 4);
`ifdef LOOP_PLAY_EN
    chk_rq("loop", 4, 0, 1, 0, 1);
    chk("loop_fin", nfin, 0);
`else
    chk_rq("loop", 3, 0, 1, 0, 0);
    chk("loop_fin", nfin, 1);
`endif

    repeat (400) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
      bus.able       = ($urandom_range(0, 7) != 0);
      bus.direc      = 1'($urandom);
      bus.twice_play = 1'($urandom);
      bus.clea       = ($urandom_range(0, 24) == 0);
      repeat ($urandom_range(1, 14)) @(negedge clk);
    end
    bus.able = 0; bus.clea = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end
endmodule
